fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO write port among NREQ producers. Each producer presents data on a valid/ready handshake. The arbiter selects one producer per cycle, tags the word with the producer index, and drives the FIFO's write enable and write data. The arbiter honours the FIFO full flag. An optional burst lock keeps one producer granted for up to BURST consecutive beats.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: state encoding and beat counter width.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int unsigned BCW = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after start, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  start,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] rot;
  int                pos;

  assign dbl = {req, req};
  // Rotate so that bit 0 is the requester at start; start is always < NREQ.
  assign rot = dbl >> start;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    // Scan downward so the lowest rotated offset wins.
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        pos   = int'(start) + k;
        if (pos >= int'(NREQ)) pos = pos - int'(NREQ);
        idx   = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, with optional burst lock.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2,
  parameter int unsigned BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [IDW+WIDTH-1:0]  fifo_wr_data,
  output logic                  grant_valid,
  output logic [IDW-1:0]        grant_id,
  output logic                  locked
);

  localparam bit LockEn = (BURST > 1);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] last_ptr_q, last_ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

  logic [IDW-1:0] start;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           beat;
  logic [WIDTH-1:0] sel_data;

  assign start = (last_ptr_q == IDW'(NREQ - 1)) ? '0 : last_ptr_q + 1'b1;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req   (req_valid),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Outputs are held quiet while reset is asserted so no write escapes mid-reset.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    if (!reset) begin
      if (state_q == ST_IDLE) begin
        grant_valid = pick_found;
        grant_id    = pick_idx;
      end else if (req_valid[owner_q]) begin
        grant_valid = 1'b1;
        grant_id    = owner_q;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_id == IDW'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign beat         = grant_valid && !fifo_full;
  assign fifo_wr_en   = beat;
  assign req_ready    = beat ? (NREQ'(1) << grant_id) : '0;
  assign fifo_wr_data = {grant_id, sel_data};
  assign locked       = (state_q == ST_LOCK);

  always_comb begin
    state_d    = state_q;
    last_ptr_d = last_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (beat) begin
          last_ptr_d = grant_id;
          if (LockEn) begin
            owner_d    = grant_id;
            beat_cnt_d = BCW'(1);
            state_d    = ST_LOCK;
          end
        end
      end
      ST_LOCK: begin
        if (!req_valid[owner_q]) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_d == BCW'(BURST)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_ptr_q <= IDW'(NREQ - 1);
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: one arbiter with BURST=1 and one with BURST=4 share the same stimulus.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        fifo_full;

  logic [3:0]  ready1, ready4;
  logic        wr_en1, wr_en4;
  logic [9:0]  wr_data1, wr_data4;
  logic        gv1, gv4;
  logic [1:0]  gid1, gid4;
  logic        locked1, locked4;

  int vectors;
  int miscompares;

  fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .IDW(2), .BURST(1)) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (ready1),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (wr_en1),
    .fifo_wr_data (wr_data1),
    .grant_valid  (gv1),
    .grant_id     (gid1),
    .locked       (locked1)
  );

  fifo_wr_arbiter #(.NREQ(4), .WIDTH(8), .IDW(2), .BURST(4)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (ready4),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (wr_en4),
    .fifo_wr_data (wr_data4),
    .grant_valid  (gv4),
    .grant_id     (gid4),
    .locked       (locked4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_id;
    logic [1:0] seq1 [5];
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req_valid   = 4'b0000;
    req_data    = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    fifo_full   = 1'b0;
    seq1        = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state with all requests low.
    @(negedge clk);
    check("rst_locked", locked4, 0);
    check("rst_wr_en", wr_en4, 0);
    check("rst_ready", ready4, 0);
    check("rst_gv", gv4, 0);
    check("rst_gid", gid4, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("idle_wr_en", wr_en4, 0);
    check("idle_gid", gid4, 0);

    // BURST=1 rotation over all four requesters.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_id = seq1[i];
      check("b1_gid", gid1, exp_id);
      check("b1_ready", ready1, 4'b0001 << exp_id);
      check("b1_wr_en", wr_en1, 1);
      check("b1_tag", wr_data1[9:8], exp_id);
      check("b1_locked", locked1, 0);
      tick();
    end

    // BURST=4 with requesters 0 and 2 contending.
    do_reset();
    req_valid = 4'b0101;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("b4_gid", gid4, (i < 4 || i == 8) ? 0 : 2);
      check("b4_wr_en", wr_en4, 1);
      check("b4_locked", locked4, (i % 4) != 0);
      check("b4_data", wr_data4[7:0], (i < 4 || i == 8) ? 8'hA0 : 8'hC2);
      tick();
    end

    // FIFO full stalls a locked burst without losing beats.
    do_reset();
    req_valid = 4'b0010;
    @(negedge clk);
    check("full_b1_gid", gid4, 1);
    tick();
    @(negedge clk);
    check("full_b2_locked", locked4, 1);
    tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_wr_en", wr_en4, 0);
      check("full_ready", ready4, 0);
      check("full_locked", locked4, 1);
      tick();
    end
    fifo_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("full_resume_wr_en", wr_en4, 1);
      check("full_resume_ready", ready4, 4'b0010);
      check("full_resume_locked", locked4, 1);
      tick();
    end
    @(negedge clk);
    check("full_end_locked", locked4, 0);
    req_valid = 4'b0000;

    // Owner drops out mid-burst; a dead cycle precedes the next grant.
    do_reset();
    req_valid = 4'b1000;
    @(negedge clk);
    check("drop_first_gid", gid4, 3);
    tick();
    req_valid = 4'b0001;
    @(negedge clk);
    check("drop_wr_en", wr_en4, 0);
    check("drop_gv", gv4, 0);
    check("drop_ready", ready4, 0);
    tick();
    @(negedge clk);
    check("drop_next_gid", gid4, 0);
    check("drop_next_wr_en", wr_en4, 1);
    check("drop_next_locked", locked4, 0);

    // Reset asserted during a lock.
    do_reset();
    req_valid = 4'b1000;
    tick();
    @(negedge clk);
    check("rl_pre_locked", locked4, 1);
    reset = 1'b1;
    #1;
    check("rl_locked", locked4, 0);
    check("rl_wr_en", wr_en4, 0);
    tick();
    check("rl_hold_wr_en", wr_en4, 0);
    check("rl_hold_ready", ready4, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rl_after_gid", gid4, 3);
      check("rl_after_locked", locked4, (i % 4) != 0);
      tick();
    end

    // Single requester: word and tag appear in the same cycle.
    do_reset();
    req_valid = 4'b0100;
    req_data[23:16] = 8'hA5;
    @(negedge clk);
    check("single_data", wr_data4, 10'h2A5);
    check("single_ready", ready4, 4'b0100);
    check("single_data_b1", wr_data1, 10'h2A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
